// File: rtl/spi_master_xfer.sv
// SPI mode-0 master: shifts one DATA_W-bit word out on MOSI, MSB first, while
// assembling DATA_W bits from MISO; registered outputs, one-cycle done strobe.
module spi_master_xfer #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic div_tc;
    assign div_tc = (div_cnt_q == DIV_LAST);

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SETUP;
            SETUP:   if (div_tc) state_d = SHIFT;
            SHIFT:   if (div_tc && sclk_q && (bit_cnt_q == BIT_LAST)) state_d = HOLD;
            HOLD:    if (div_tc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                div_cnt_d = '0;
                if (start) begin
                    tx_sr_d   = tx_data;
                    mosi_d    = tx_data[DATA_W-1];
                    rx_sr_d   = '0;
                    bit_cnt_d = '0;
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            SETUP: begin
                if (div_tc) begin
                    // The first sclk rise happens here, so MISO is captured now.
                    div_cnt_d = '0;
                    sclk_d    = 1'b1;
                    rx_sr_d   = {rx_sr_q[DATA_W-2:0], miso};
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (div_tc) begin
                    div_cnt_d = '0;
                    if (sclk_q) begin
                        sclk_d    = 1'b0;
                        tx_sr_d   = {tx_sr_q[DATA_W-2:0], 1'b0};
                        mosi_d    = tx_sr_q[DATA_W-2];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else begin
                        sclk_d  = 1'b1;
                        rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (div_tc) begin
                    div_cnt_d = '0;
                    cs_n_d    = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_sr_q;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            default: begin
                div_cnt_d = '0;
            end
        endcase
    end

    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;

endmodule
